// File: rtl/pipe_adder_pkg.sv
// Shared constants and elaboration helpers for pipe_adder.
package pipe_adder_pkg;

  localparam logic RST_VAL = '0;

  function automatic int chunk_w(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_full_adder.sv
// One-bit full adder cell; chained per chunk inside pipe_adder.
module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic count
);

  assign sum   = in1 ^ in2 ^ cin;
  assign count = (in1 & in2) | (cin & (in1 ^ in2));

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple adder, one WIDTH/STAGES chunk per stage, full-stall valid/ready.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             count
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipe_adder: WIDTH must be a positive multiple of STAGES, STAGES <= WIDTH");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_sum_out;

  // Valid shift chain; the last tap is the output valid.
  for (genvar k = 0; k < STAGES; k++) begin : g_vld
    logic w_d;
    logic r_v;
    if (k == 0) begin : g_src
      assign w_d = in_valid;
    end else begin : g_src
      assign w_d = g_vld[k-1].r_v;
    end
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        r_v <= RST_VAL;
      end else if (w_adv) begin
        r_v <= w_d;
      end
    end
  end

  assign out_valid = g_vld[STAGES-1].r_v;
  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;

  for (genvar j = 0; j < STAGES; j++) begin : g_chunk
    logic [CW-1:0] w_a;
    logic [CW-1:0] w_b;
    logic [CW-1:0] w_s;
    logic [CW:0]   w_c;
    logic          w_cin;
    logic          r_carry;

    // Chunk j of the operands waits j cycles so it meets its carry.
    if (j == 0) begin : g_opnd
      assign w_a = in1[CW-1:0];
      assign w_b = in2[CW-1:0];
    end else begin : g_opnd
      for (genvar t = 0; t < j; t++) begin : g_tap
        logic [CW-1:0] w_a_d;
        logic [CW-1:0] w_b_d;
        logic [CW-1:0] r_a;
        logic [CW-1:0] r_b;
        if (t == 0) begin : g_src
          assign w_a_d = in1[j*CW +: CW];
          assign w_b_d = in2[j*CW +: CW];
        end else begin : g_src
          assign w_a_d = g_tap[t-1].r_a;
          assign w_b_d = g_tap[t-1].r_b;
        end
        always_ff @(posedge sys_clk) begin
          if (sys_rst) begin
            r_a <= {CW{RST_VAL}};
            r_b <= {CW{RST_VAL}};
          end else if (w_adv) begin
            r_a <= w_a_d;
            r_b <= w_b_d;
          end
        end
      end
      assign w_a = g_tap[j-1].r_a;
      assign w_b = g_tap[j-1].r_b;
    end

    if (j == 0) begin : g_cin
      assign w_cin = cin;
    end else begin : g_cin
      assign w_cin = g_chunk[j-1].r_carry;
    end

    assign w_c[0] = w_cin;
    for (genvar b = 0; b < CW; b++) begin : g_bit
      full_adder u_fa (
        .in1   (w_a[b]),
        .in2   (w_b[b]),
        .cin   (w_c[b]),
        .sum   (w_s[b]),
        .count (w_c[b+1])
      );
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        r_carry <= RST_VAL;
      end else if (w_adv) begin
        r_carry <= w_c[CW];
      end
    end

    // Sum chunk j is held STAGES-j cycles so every chunk leaves together.
    for (genvar t = 0; t < STAGES - j; t++) begin : g_sdl
      logic [CW-1:0] w_s_d;
      logic [CW-1:0] r_s;
      if (t == 0) begin : g_src
        assign w_s_d = w_s;
      end else begin : g_src
        assign w_s_d = g_sdl[t-1].r_s;
      end
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          r_s <= {CW{RST_VAL}};
        end else if (w_adv) begin
          r_s <= w_s_d;
        end
      end
    end

    assign w_sum_out[j*CW +: CW] = g_sdl[STAGES-j-1].r_s;
  end

  assign sum   = w_sum_out;
  assign count = g_chunk[STAGES-1].r_carry;

`ifdef PIPE_ADDER_OVF_EN
  logic w_ovf_d;
  logic r_ovf;

  assign w_ovf_d = (g_chunk[STAGES-1].w_a[CW-1] == g_chunk[STAGES-1].w_b[CW-1]) &&
                   (g_chunk[STAGES-1].w_s[CW-1] != g_chunk[STAGES-1].w_a[CW-1]);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_ovf <= RST_VAL;
    end else if (w_adv) begin
      r_ovf <= w_ovf_d;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined multi-bit adder. It succeeds the 1-bit half adder and is built from chained 1-bit full-adder cells.
- The operand width is split into STAGES equal chunks. One chunk is added per pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on input and output lets it sit in streaming datapaths, such as the accumulator and counter blocks.

Parameters:
- WIDTH, 8: operand and sum width in bits. Must be ≥1.
- STAGES, 2: number of pipeline stages; this is also the latency. Must satisfy 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0.

Ports:
- sys_clk, input, 1: system clock. All logic is on the rising edge.
- sys_rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operands present this cycle.
- in_ready, output, 1: block accepts operands this cycle.
- in1, input, WIDTH: operand A, unsigned.
- in2, input, WIDTH: operand B, unsigned.
- cin, input, 1: carry-in.
- out_valid, output, 1: result present.
- out_ready, input, 1: downstream accepts result.
- sum, output, WIDTH: in1 + in2 + cin, truncated to WIDTH.
- count, output, 1: carry-out, the bit WIDTH of the full sum.

Behaviour:
- Reset:
  - All stage valid bits, sum, count and every internal pipeline register clear to 0 on the first sys_clk edge with sys_rst=1.
  - in_ready = 1 from the first cycle after reset is released.
- Definitions:
  - Chunk width CW = WIDTH/STAGES.
  - Stage k (0..STAGES-1) adds bits [k*CW +: CW] of the delayed operands plus carry c[k].
  - c[0] = cin. c[k+1] = registered carry-out of stage k.
- Alignment registers:
  - Higher operand chunks are delayed k cycles before use.
  - Lower sum chunks are delayed so that all chunks of one transaction emerge together.
- Stall rule: global advance enable adv = !out_valid || out_ready.
  - in_ready = adv. This is combinational and has no dependency on in_valid.
  - When adv=1, every stage register loads from its predecessor; stage 0 loads from the inputs with valid = in_valid.
  - When adv=0, all pipeline registers hold. This includes bubbles: a full stall, not bubble-collapsing.
- Latency and throughput:
  - A transfer occurs when in_valid && in_ready.
  - Its result appears with out_valid=1 exactly STAGES cycles later, absent stalls.
  - Throughput is 1 per cycle under continuous out_ready=1.
- Output stability: while out_valid=1 && out_ready=0, sum and count hold.
- Bubbles:
  - Invalid slots propagate as out_valid=0.
  - sum and count are don't-care when out_valid=0, but must not be X after reset.
- Wrap-around:
  - All-ones + 1 gives sum=0, count=1.
  - All-ones + all-ones + cin=1 gives sum=all-ones, count=1.
- STAGES=1: single registered adder with latency 1.
- Reset mid-operation: in-flight transactions are discarded with no output pulse; out_valid=0 on the cycle after reset asserts.
- Simultaneous events: while out_valid=1 and out_ready=1, a new input is accepted in the same cycle (in_ready=1).

Optional Feature:
- Macro: PIPE_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), the two's-complement signed overflow of the final sum.
  - ovf = (in1[MSB]==in2[MSB]) && (sum[MSB]!=in1[MSB]), using the delayed operand MSBs.
  - ovf is aligned and stalled with sum; reset value 0.
- Undefined: the ovf port and its logic are absent.

Decomposition:
- Package pipe_adder_pkg:
  - localparam-style function chunk_w(WIDTH, STAGES).
  - Reset-value constant RST_VAL='0.
  - Elaboration check that WIDTH % STAGES == 0.
- Sub-module full_adder, one bit:
  - Inputs in1, in2, cin; outputs sum, count.
  - Instantiated CW times per stage in a generate loop to form a ripple chunk.

Test Plan (WIDTH=8, STAGES=2 unless noted):
- Reset, then in1=0x0F, in2=0x01, cin=0, in_valid for 1 cycle, out_ready=1 -> 2 cycles later out_valid=1 for 1 cycle, sum=0x10, count=0.
- in1=0xFF, in2=0x01, cin=0 -> sum=0x00, count=1. Then in1=0xFF, in2=0xFF, cin=1 -> sum=0xFF, count=1. These check the carry across the chunk boundary.
- 4 back-to-back transfers: (1,2), (3,4), (0x80,0x80), (0x7F,0x01), out_ready=1 -> results 0x03, 0x07, 0x00/c1, 0x80 on consecutive cycles, in order.
- Backpressure:
  - Hold out_ready=0 while the first result is valid -> in_ready=0, and sum/count stay stable for 5 cycles.
  - Release -> remaining results drain in order with none lost or duplicated.
- Assert sys_rst while 2 transactions are in flight -> out_valid=0 the next cycle and no stale result after reset is released.
- With PIPE_ADDER_OVF_EN: 0x7F+0x01 -> ovf=1; 0x80+0x80 -> ovf=1, count=1; 0x10+0x20 -> ovf=0.
- Random sweep: 1000 random transfers with STAGES ∈ {1,2,4,8} compared against a reference model of in1+in2+cin, with random out_ready stalls.
